// File: rtl/play_core_pkg.sv
// Shared constants and types for the playback engine.
// Holds default widths, FIFO depth and the play FSM state encoding.
package play_core_pkg;

    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_ABORT,
        S_FINISH
    } play_state_t;

endpackage

// File: rtl/play_fifo.sv
// Prefetch FIFO between the SDRAM read side and the DAC stream.
// Ports: clk, rst_n, push/push_data, pop, flush -> head, full, empty, count.
module play_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the DAC data output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/play_core.sv
// Playback engine: sequential SDRAM fetch into a prefetch FIFO, streamed to the DAC.
// Ports: control (start/stop/pause/loop, done/busy), SDRAM read side, DAC valid/ready side.
module play_core #(
    parameter int ADDR_W     = play_core_pkg::ADDR_W,
    parameter int DATA_W     = play_core_pkg::DATA_W,
    parameter int FIFO_DEPTH = play_core_pkg::FIFO_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_start_addr,
    input  logic [ADDR_W-1:0] play_length,
    input  logic              play_loop,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    output logic              play_busy,
    output logic              play_read,
    output logic [ADDR_W-1:0] play_addr,
    input  logic [DATA_W-1:0] play_readdata,
    input  logic              play_sdram_finished,
    output logic [DATA_W-1:0] play_audio_data,
    output logic              play_audio_valid,
    input  logic              play_audio_ready
);

    import play_core_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    play_state_t       state;
    play_state_t       state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] base_len;
    logic              loop_flag;
    logic              read_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic              start_ok;
    logic              read_done;
    logic              last_word;
    logic              have_space;
    logic              launch;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;

    assign read_done  = read_q && play_sdram_finished;
    assign last_word  = (remaining == ADDR_W'(1));
    // The in-flight word already owns a slot.
    assign have_space = !fifo_full &&
        ((fifo_count + CNT_W'(read_q)) < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_ok   = 1'b0;
        launch     = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (play_start) begin
                    start_ok  = 1'b1;
                    state_nxt = (play_length == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                // Stop beats both pause and a loop reload.
                if (play_stop) begin
                    state_nxt = S_ABORT;
                end else begin
                    fifo_push = read_done;
                    launch    = !read_q && (remaining != '0) &&
                                !play_pause && have_space;
                    if (read_done && last_word && !loop_flag) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (play_stop) begin
                    state_nxt = S_ABORT;
                end else if (fifo_empty) begin
                    state_nxt = S_FINISH;
                end
            end
            S_ABORT: begin
                // Wait out any open SDRAM read; its data is dropped.
                fifo_flush = 1'b1;
                if ((!read_q || play_sdram_finished) && fifo_empty) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cur_addr  <= '0;
            base_addr <= '0;
            remaining <= '0;
            base_len  <= '0;
            loop_flag <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                cur_addr  <= play_start_addr;
                base_addr <= play_start_addr;
                remaining <= play_length;
                base_len  <= play_length;
                loop_flag <= play_loop;
            end
            if (launch) begin
                read_q <= 1'b1;
            end else if (read_done) begin
                read_q <= 1'b0;
            end
            if (fifo_push) begin
                if (last_word && loop_flag) begin
                    cur_addr  <= base_addr;
                    remaining <= base_len;
                end else begin
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
            end
        end
    end

    assign fifo_pop = play_audio_valid && play_audio_ready;

    play_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .push      (fifo_push),
        .push_data (play_readdata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign play_read        = read_q;
    assign play_addr        = cur_addr;
    assign play_done        = (state == S_FINISH);
    assign play_busy        = (state != S_IDLE);
    assign play_audio_data  = fifo_head;
    assign play_audio_valid = !fifo_empty && !play_pause &&
                              (state != S_ABORT);

endmodule

// File: tb/tb_play_core.sv
// Directed testbench for play_core.
// Models a fixed-latency SDRAM and logs reads, DAC pops and done pulses.
module tb_play_core;

    logic        clk;
    logic        rst;
    logic        play_start;
    logic [22:0] play_start_addr;
    logic [22:0] play_length;
    logic        play_loop;
    logic        play_pause;
    logic        play_stop;
    logic        play_done;
    logic        play_busy;
    logic        play_read;
    logic [22:0] play_addr;
    logic [15:0] play_readdata;
    logic        play_sdram_finished;
    logic [15:0] play_audio_data;
    logic        play_audio_valid;
    logic        play_audio_ready;

    int tests_run;
    int tests_failed;

    int          lat;
    int          cnt;
    int          fin_cnt;
    int          done_cnt;
    logic        read_prev;
    logic [22:0] reads_q[$];
    logic [15:0] pops_q[$];

    play_core dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .play_start          (play_start),
        .play_start_addr     (play_start_addr),
        .play_length         (play_length),
        .play_loop           (play_loop),
        .play_pause          (play_pause),
        .play_stop           (play_stop),
        .play_done           (play_done),
        .play_busy           (play_busy),
        .play_read           (play_read),
        .play_addr           (play_addr),
        .play_readdata       (play_readdata),
        .play_sdram_finished (play_sdram_finished),
        .play_audio_data     (play_audio_data),
        .play_audio_valid    (play_audio_valid),
        .play_audio_ready    (play_audio_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dval(input logic [22:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // SDRAM: finishes a read lat cycles after it appears.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            play_sdram_finished = 1'b0;
            cnt = 0;
        end else if (play_sdram_finished) begin
            play_sdram_finished = 1'b0;
        end else if (play_read) begin
            cnt++;
            if (cnt >= lat) begin
                play_sdram_finished = 1'b1;
                play_readdata = dval(play_addr);
                cnt = 0;
                fin_cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (play_read && !read_prev) reads_q.push_back(play_addr);
        read_prev = play_read;
        if (play_audio_valid && play_audio_ready)
            pops_q.push_back(play_audio_data);
        if (play_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        reads_q.delete();
        pops_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [22:0] a, input logic [22:0] l,
                            input logic lp);
        play_start_addr = a;
        play_length     = l;
        play_loop       = lp;
        play_start      = 1'b1;
        tick();
        play_start      = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int n;
        n = 0;
        while (!play_done && n < max) begin
            tick();
            n++;
        end
        tests_run++;
        if (!play_done) begin
            tests_failed++;
            $display("FAIL %s done timeout: got 0 after %0d cycles, need 1",
                     name, max);
        end
        tick();
        tick();
    endtask

    task automatic wait_read(input int max, input string name);
        int n;
        n = 0;
        while (!play_read && n < max) begin
            tick();
            n++;
        end
        tests_run++;
        if (!play_read) begin
            tests_failed++;
            $display("FAIL %s read timeout: got 0, need 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tests_run++;
        if ({play_done, play_busy, play_read, play_audio_valid} !== 4'b0 ||
            play_addr !== 23'd0 || play_audio_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got d%b b%b r%b v%b a%h q%h, need 0",
                     play_done, play_busy, play_read, play_audio_valid,
                     play_addr, play_audio_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_logs();
        lat = 2;
        play_audio_ready = 1'b1;
        do_start(23'h100, 23'd3, 1'b0);
        tests_run++;
        if (play_busy !== 1'b1 || play_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_accept: busy %b read %b, need 1 0",
                     play_busy, play_read);
        end
        tick();
        tests_run++;
        if (play_read !== 1'b1 || play_addr !== 23'h100) begin
            tests_failed++;
            $display("FAIL basic_latency: read %b addr %h, need 1 100",
                     play_read, play_addr);
        end
        wait_done(60, "basic");
        tests_run++;
        if (reads_q.size() != 3 || pops_q.size() != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL basic_counts: reads %0d pops %0d done %0d, need 3 3 1",
                     reads_q.size(), pops_q.size(), done_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (reads_q[i] !== 23'h100 + 23'(i) ||
                    pops_q[i] !== dval(23'h100 + 23'(i))) begin
                    tests_failed++;
                    $display("FAIL basic_order[%0d]: addr %h data %h, need %h %h",
                             i, reads_q[i], pops_q[i], 23'h100 + 23'(i),
                             dval(23'h100 + 23'(i)));
                end
            end
        end
        tests_run++;
        if (play_busy !== 1'b0 || play_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: busy %b done %b, need 0 0",
                     play_busy, play_done);
        end
    endtask

    task automatic test_zero_len();
        int n;
        clear_logs();
        do_start(23'h40, 23'd0, 1'b0);
        n = 0;
        while (!play_done && n < 2) begin
            tick();
            n++;
        end
        tests_run++;
        if (play_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_len_done: got 0 within 2 cycles, need 1");
        end
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (reads_q.size() != 0 || done_cnt != 1 || play_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_quiet: reads %0d done %0d busy %b, need 0 1 0",
                     reads_q.size(), done_cnt, play_busy);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        lat = 2;
        play_audio_ready = 1'b0;
        do_start(23'h200, 23'd10, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        tests_run++;
        if (reads_q.size() != 4 || play_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_fill: reads %0d read %b, need 4 0",
                     reads_q.size(), play_read);
        end
        tests_run++;
        if (play_audio_valid !== 1'b1 || play_audio_data !== dval(23'h200)) begin
            tests_failed++;
            $display("FAIL bp_head: valid %b data %h, need 1 %h",
                     play_audio_valid, play_audio_data, dval(23'h200));
        end
        play_audio_ready = 1'b1;
        wait_done(120, "bp");
        tests_run++;
        if (reads_q.size() != 10 || pops_q.size() != 10) begin
            tests_failed++;
            $display("FAIL bp_counts: reads %0d pops %0d, need 10 10",
                     reads_q.size(), pops_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests_run++;
                if (reads_q[i] !== 23'h200 + 23'(i) ||
                    pops_q[i] !== dval(23'h200 + 23'(i))) begin
                    tests_failed++;
                    $display("FAIL bp_order[%0d]: addr %h data %h, need %h %h",
                             i, reads_q[i], pops_q[i], 23'h200 + 23'(i),
                             dval(23'h200 + 23'(i)));
                end
            end
        end
    endtask

    task automatic test_pause();
        int f0;
        clear_logs();
        lat = 4;
        play_audio_ready = 1'b1;
        f0 = fin_cnt;
        do_start(23'h300, 23'd6, 1'b0);
        wait_read(10, "pause");
        play_pause = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        tests_run++;
        if (reads_q.size() != 1 || fin_cnt - f0 != 1 || play_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_hold: reads %0d fins %0d read %b, need 1 1 0",
                     reads_q.size(), fin_cnt - f0, play_read);
        end
        tests_run++;
        if (play_audio_valid !== 1'b0 || pops_q.size() != 0) begin
            tests_failed++;
            $display("FAIL pause_out: valid %b pops %0d, need 0 0",
                     play_audio_valid, pops_q.size());
        end
        play_pause = 1'b0;
        wait_done(100, "pause");
        tests_run++;
        if (reads_q.size() != 6 || pops_q.size() != 6) begin
            tests_failed++;
            $display("FAIL pause_counts: reads %0d pops %0d, need 6 6",
                     reads_q.size(), pops_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (reads_q[i] !== 23'h300 + 23'(i) ||
                    pops_q[i] !== dval(23'h300 + 23'(i))) begin
                    tests_failed++;
                    $display("FAIL pause_order[%0d]: addr %h data %h, need %h %h",
                             i, reads_q[i], pops_q[i], 23'h300 + 23'(i),
                             dval(23'h300 + 23'(i)));
                end
            end
        end
    endtask

    task automatic test_stop();
        int f0;
        int n;
        clear_logs();
        lat = 6;
        play_audio_ready = 1'b0;
        f0 = fin_cnt;
        do_start(23'h400, 23'd8, 1'b0);
        n = 0;
        while (!(play_read && fin_cnt - f0 == 1) && n < 40) begin
            tick();
            n++;
        end
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        tests_run++;
        if (play_read !== 1'b1 || play_audio_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_hold: read %b valid %b, need 1 0",
                     play_read, play_audio_valid);
        end
        wait_done(40, "stop");
        play_audio_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (reads_q.size() != 2 || fin_cnt - f0 != 2 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL stop_end: reads %0d fins %0d done %0d, need 2 2 1",
                     reads_q.size(), fin_cnt - f0, done_cnt);
        end
        tests_run++;
        if (pops_q.size() != 0 || play_audio_valid !== 1'b0 ||
            play_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_flush: pops %0d valid %b busy %b, need 0 0 0",
                     pops_q.size(), play_audio_valid, play_busy);
        end
        clear_logs();
        lat = 2;
        do_start(23'h500, 23'd2, 1'b0);
        wait_done(40, "restart");
        tests_run++;
        if (reads_q.size() != 2 || pops_q.size() != 2 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL restart_counts: reads %0d pops %0d done %0d, need 2 2 1",
                     reads_q.size(), pops_q.size(), done_cnt);
        end else begin
            tests_run++;
            if (reads_q[1] !== 23'h501 || pops_q[0] !== dval(23'h500) ||
                pops_q[1] !== dval(23'h501)) begin
                tests_failed++;
                $display("FAIL restart_data: addr %h data %h %h, need 501 %h %h",
                         reads_q[1], pops_q[0], pops_q[1],
                         dval(23'h500), dval(23'h501));
            end
        end
    endtask

    task automatic test_loop();
        int n;
        logic [22:0] ea;
        clear_logs();
        lat = 2;
        play_audio_ready = 1'b1;
        do_start(23'h7FFFFF, 23'd2, 1'b1);
        n = 0;
        while (reads_q.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        tests_run++;
        if (done_cnt != 0 || play_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL loop_running: done %0d busy %b, need 0 1",
                     done_cnt, play_busy);
        end
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        wait_done(40, "loop");
        tests_run++;
        if (reads_q.size() < 6 || pops_q.size() < 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL loop_counts: reads %0d pops %0d done %0d, need >=6 >=4 1",
                     reads_q.size(), pops_q.size(), done_cnt);
        end else begin
            for (int i = 0; i < 6; i++) begin
                ea = (i % 2 == 0) ? 23'h7FFFFF : 23'h000000;
                tests_run++;
                if (reads_q[i] !== ea) begin
                    tests_failed++;
                    $display("FAIL loop_addr[%0d]: got %h, need %h",
                             i, reads_q[i], ea);
                end
            end
            for (int i = 0; i < 4; i++) begin
                ea = (i % 2 == 0) ? 23'h7FFFFF : 23'h000000;
                tests_run++;
                if (pops_q[i] !== dval(ea)) begin
                    tests_failed++;
                    $display("FAIL loop_data[%0d]: got %h, need %h",
                             i, pops_q[i], dval(ea));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        lat = 8;
        play_audio_ready = 1'b0;
        do_start(23'h600, 23'd5, 1'b0);
        wait_read(10, "areset");
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({play_done, play_busy, play_read, play_audio_valid} !== 4'b0 ||
            play_addr !== 23'd0 || play_audio_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL areset_outputs: d%b b%b r%b v%b a%h q%h, need 0",
                     play_done, play_busy, play_read, play_audio_valid,
                     play_addr, play_audio_data);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (play_busy !== 1'b0 || play_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_idle: busy %b read %b, need 0 0",
                     play_busy, play_read);
        end
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        lat                 = 2;
        cnt                 = 0;
        fin_cnt             = 0;
        done_cnt            = 0;
        read_prev           = 1'b0;
        rst                 = 1'b0;
        play_start          = 1'b0;
        play_start_addr     = '0;
        play_length         = '0;
        play_loop           = 1'b0;
        play_pause          = 1'b0;
        play_stop           = 1'b0;
        play_readdata       = '0;
        play_sdram_finished = 1'b0;
        play_audio_ready    = 1'b1;

        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_pause();
        test_stop();
        test_loop();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
